write_back: RTL

// Final pipeline stage. Drives the decode stage's register-file write port (write_result/write_addr/register_write).

---
 rtl/write_back_if.sv | 18 +
 rtl/write_back.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/write_back_if.sv
// Long-latency result handshake between the HI/LO mul/div unit and write-back.
// master: lu_valid/lu_result/lu_dest out, lu_ready in; slave: the reverse.
interface write_back_if;
  logic        lu_valid;
  logic        lu_ready;
  logic [31:0] lu_result;
  logic [4:0]  lu_dest;

  modport master (
    output lu_valid, lu_result, lu_dest,
    input  lu_ready
  );

  modport slave (
    input  lu_valid, lu_result, lu_dest,
    output lu_ready
  );
endinterface

// File: rtl/write_back.sv
// Write-back stage: merges MEM-stage results and buffered long-latency
// mul/div results onto the single register-file write port. MEM wins the
// port; FIFO entries drain into idle slots.
// Ports: clk, reset (sync, active-high); mem_* MEM-stage slot; lu (slave
// handshake, write_back_if); write_result/write_addr/register_write to
// decode; q_addr_a/b in, q_busy_a/b out (pending-write query).
// Optional: define WB_HAZARD_EN to build the pending-write query logic;
// otherwise q_busy_a/b are tied to 0.
module write_back #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic        mem_to_reg,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_data,
  input  logic [4:0]  mem_dest,
  write_back_if.slave lu,
  output logic [31:0] write_result,
  output logic [4:0]  write_addr,
  output logic        register_write,
  input  logic [4:0]  q_addr_a,
  input  logic [4:0]  q_addr_b,
  output logic        q_busy_a,
  output logic        q_busy_b
);

  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      res_q [DEPTH];
  logic [4:0]       dst_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] data_q, data_d;
  logic [4:0]  addr_q, addr_d;
  logic        we_q, we_d;

  logic        pipe_hit;
  logic        push;
  logic        pop;
  logic [7:0]  byte_l;
  logic [15:0] half_l;
  logic [31:0] load_data;

  assign pipe_hit = mem_valid & mem_reg_write & (mem_dest != 5'd0);
  assign lu.lu_ready = (count_q < CNT_W'(DEPTH));
  // $0 offers complete the handshake but are dropped here.
  assign push = lu.lu_valid & lu.lu_ready & (lu.lu_dest != 5'd0);
  // count_q excludes this cycle's push, so a new entry cannot pop at once.
  assign pop  = ~pipe_hit & (count_q != '0);

  always_comb begin
    byte_l = mem_data[7:0];
    unique case (alu_result[1:0])
      2'd0: byte_l = mem_data[7:0];
      2'd1: byte_l = mem_data[15:8];
      2'd2: byte_l = mem_data[23:16];
      2'd3: byte_l = mem_data[31:24];
    endcase
    half_l = alu_result[1] ? mem_data[31:16] : mem_data[15:0];
    unique case (mem_size)
      2'b00:   load_data = {{24{mem_signed & byte_l[7]}}, byte_l};
      2'b01:   load_data = {{16{mem_signed & half_l[15]}}, half_l};
      default: load_data = mem_data;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (pipe_hit) begin
      we_d   = 1'b1;
      addr_d = mem_dest;
      data_d = mem_to_reg ? load_data : alu_result;
    end else if (pop) begin
      we_d   = 1'b1;
      addr_d = dst_q[rd_ptr_q];
      data_d = res_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset; only entries inside count are ever read.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      res_q[wr_ptr_q] <= lu.lu_result;
      dst_q[wr_ptr_q] <= lu.lu_dest;
    end
  end

  assign write_result   = data_q;
  assign write_addr     = addr_q;
  assign register_write = we_q;

`ifdef WB_HAZARD_EN
  logic [PTR_W-1:0] idx;

  // Scans registered state: a popping entry still counts, a pushing one not.
  always_comb begin
    q_busy_a = 1'b0;
    q_busy_b = 1'b0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (dst_q[idx] == q_addr_a && q_addr_a != 5'd0) q_busy_a = 1'b1;
        if (dst_q[idx] == q_addr_b && q_addr_b != 5'd0) q_busy_b = 1'b1;
      end
    end
  end
`else
  logic unused_q_addr;
  assign unused_q_addr = ^{q_addr_a, q_addr_b};
  assign q_busy_a = 1'b0;
  assign q_busy_b = 1'b0;
`endif

endmodule
